// File: rtl/sdr_16_responder.sv
// Single-data-rate 16-bit SDRAM device model: command decode, per-bank open rows, mode register,
// burst engine over an internal RAM. Define SDR_PROTOCOL_CHECK_EN to enable the sticky err checker.
module sdr_16_responder #(
    parameter int ba_size      = 2,
    parameter int row_size     = 13,
    parameter int col_size     = 9,
    parameter int mem_adr_size = 12,
    parameter int trcd         = 2,
    parameter int trp          = 2
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    input  logic [ba_size-1:0]  ba,
    input  logic [row_size-1:0] a,
    input  logic [2:0]          cmd,
    input  logic [15:0]         dq_i,
    output logic [15:0]         dq_o,
    output logic                dq_o_en,
    output logic [3:0]          err
);

    localparam int NB = 1 << ba_size;

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PCH = 3'b010;
    localparam logic [2:0] CMD_LMR = 3'b000;

    logic [NB-1:0]                open_q, open_d;
    logic [NB-1:0][row_size-1:0]  row_q, row_d;
    logic                         wb_q, wb_d, bt_q, bt_d;
    logic [2:0]                   cl_q, cl_d, bl_q, bl_d;

    logic                         bst_act_q, bst_act_d, bst_wr_q, bst_wr_d;
    logic [ba_size-1:0]           bst_ba_q, bst_ba_d;
    logic [row_size-1:0]          bst_row_q, bst_row_d;
    logic [col_size-1:0]          bst_col_q, bst_col_d;
    logic [2:0]                   bst_k_q, bst_k_d, bst_mask_q, bst_mask_d;
    logic                         bst_bt_q, bst_bt_d, bst_cl3_q, bst_cl3_d;

    logic [1:0]                   pipe_v_q, pipe_v_d;
    logic [1:0][15:0]             pipe_d_q, pipe_d_d;
    logic [15:0]                  dq_o_q, dq_o_d;
    logic                         dq_o_en_q, dq_o_en_d;

    logic                         is_act, is_rd, is_wr, is_pch, is_lmr, rw_cmd, rw_ok, pch_hit;
    logic [2:0]                   mode_mask;
    logic                         mode_cl3;
    logic [col_size-1:0]          cur_start, mask_ext, low_ext;
    logic [2:0]                   cur_k, cur_mask, low;
    logic                         cur_bt;
    logic                         beat_v, beat_wr, beat_cl3;
    logic [ba_size-1:0]           beat_ba;
    logic [row_size-1:0]          beat_row;
    logic [col_size-1:0]          beat_col;
    logic [mem_adr_size-1:0]      ram_adr;
    logic [15:0]                  ram_rd;
    logic [15:0]                  mem [0:(1<<mem_adr_size)-1];

    assign is_act  = (cmd == CMD_ACT);
    assign is_rd   = (cmd == CMD_RD);
    assign is_wr   = (cmd == CMD_WR);
    assign is_pch  = (cmd == CMD_PCH);
    assign is_lmr  = (cmd == CMD_LMR);
    assign rw_cmd  = is_rd | is_wr;
    assign rw_ok   = rw_cmd & open_q[ba];
    assign pch_hit = is_pch & bst_act_q & (a[10] | (ba == bst_ba_q));

    // Reserved burst-length and CAS codes fall back to 1 beat and CL2.
    always_comb begin
        case (bl_q)
            3'b001:  mode_mask = 3'd1;
            3'b010:  mode_mask = 3'd3;
            3'b011:  mode_mask = 3'd7;
            default: mode_mask = 3'd0;
        endcase
        mode_cl3 = (cl_q == 3'd3);
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        wb_d   = wb_q;
        cl_d   = cl_q;
        bt_d   = bt_q;
        bl_d   = bl_q;
        if (is_act) begin
            open_d[ba] = 1'b1;
            row_d[ba]  = a;
        end
        if (is_pch) begin
            if (a[10]) open_d = '0;
            else       open_d[ba] = 1'b0;
        end
        if (rw_ok && a[10]) open_d[ba] = 1'b0;
        if (is_lmr) begin
            wb_d = a[9];
            cl_d = a[6:4];
            bt_d = a[3];
            bl_d = a[2:0];
        end
    end

    // Beat 0 is taken straight from the command; later beats come from the latched burst state.
    always_comb begin
        cur_start  = bst_col_q;
        cur_k      = bst_k_q;
        cur_mask   = bst_mask_q;
        cur_bt     = bst_bt_q;
        beat_v     = 1'b0;
        beat_wr    = bst_wr_q;
        beat_ba    = bst_ba_q;
        beat_row   = bst_row_q;
        beat_cl3   = bst_cl3_q;
        bst_act_d  = bst_act_q;
        bst_wr_d   = bst_wr_q;
        bst_ba_d   = bst_ba_q;
        bst_row_d  = bst_row_q;
        bst_col_d  = bst_col_q;
        bst_k_d    = bst_k_q;
        bst_mask_d = bst_mask_q;
        bst_bt_d   = bst_bt_q;
        bst_cl3_d  = bst_cl3_q;
        if (rw_ok) begin
            cur_start  = a[col_size-1:0];
            cur_k      = 3'd0;
            cur_mask   = (is_wr && wb_q) ? 3'd0 : mode_mask;
            cur_bt     = bt_q;
            beat_v     = 1'b1;
            beat_wr    = is_wr;
            beat_ba    = ba;
            beat_row   = row_q[ba];
            beat_cl3   = mode_cl3;
            bst_act_d  = (cur_mask != 3'd0);
            bst_wr_d   = is_wr;
            bst_ba_d   = ba;
            bst_row_d  = row_q[ba];
            bst_col_d  = a[col_size-1:0];
            bst_k_d    = 3'd1;
            bst_mask_d = cur_mask;
            bst_bt_d   = bt_q;
            bst_cl3_d  = mode_cl3;
        end else if (bst_act_q && !pch_hit) begin
            beat_v    = 1'b1;
            bst_k_d   = bst_k_q + 3'd1;
            bst_act_d = (bst_k_q != bst_mask_q);
        end else if (pch_hit) begin
            bst_act_d = 1'b0;
        end
        low      = cur_bt ? (cur_start[2:0] ^ cur_k) : (cur_start[2:0] + cur_k);
        mask_ext = {{(col_size-3){1'b0}}, cur_mask};
        low_ext  = {{(col_size-3){1'b0}}, low};
        beat_col = (cur_start & ~mask_ext) | (low_ext & mask_ext);
    end

    assign ram_adr = mem_adr_size'({beat_ba, beat_row, beat_col});
    assign ram_rd  = mem[ram_adr];

    always_ff @(posedge sdram_clk) begin
        if (beat_v && beat_wr) mem[ram_adr] <= dq_i;
    end

    // CL3 fetches enter one stage further from the output than CL2 fetches.
    always_comb begin
        pipe_v_d    = {1'b0, pipe_v_q[1]};
        pipe_d_d[1] = '0;
        pipe_d_d[0] = pipe_d_q[1];
        if (beat_v && !beat_wr) begin
            if (beat_cl3) begin
                pipe_v_d[1] = 1'b1;
                pipe_d_d[1] = ram_rd;
            end else begin
                pipe_v_d[0] = 1'b1;
                pipe_d_d[0] = ram_rd;
            end
        end
        dq_o_d    = pipe_v_q[0] ? pipe_d_q[0] : 16'h0000;
        dq_o_en_d = pipe_v_q[0];
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            open_q     <= '0;
            row_q      <= '0;
            wb_q       <= 1'b0;
            cl_q       <= 3'd2;
            bt_q       <= 1'b0;
            bl_q       <= 3'b001;
            bst_act_q  <= 1'b0;
            bst_wr_q   <= 1'b0;
            bst_ba_q   <= '0;
            bst_row_q  <= '0;
            bst_col_q  <= '0;
            bst_k_q    <= '0;
            bst_mask_q <= '0;
            bst_bt_q   <= 1'b0;
            bst_cl3_q  <= 1'b0;
            pipe_v_q   <= '0;
            pipe_d_q   <= '0;
            dq_o_q     <= '0;
            dq_o_en_q  <= 1'b0;
        end else begin
            open_q     <= open_d;
            row_q      <= row_d;
            wb_q       <= wb_d;
            cl_q       <= cl_d;
            bt_q       <= bt_d;
            bl_q       <= bl_d;
            bst_act_q  <= bst_act_d;
            bst_wr_q   <= bst_wr_d;
            bst_ba_q   <= bst_ba_d;
            bst_row_q  <= bst_row_d;
            bst_col_q  <= bst_col_d;
            bst_k_q    <= bst_k_d;
            bst_mask_q <= bst_mask_d;
            bst_bt_q   <= bst_bt_d;
            bst_cl3_q  <= bst_cl3_d;
            pipe_v_q   <= pipe_v_d;
            pipe_d_q   <= pipe_d_d;
            dq_o_q     <= dq_o_d;
            dq_o_en_q  <= dq_o_en_d;
        end
    end

    assign dq_o    = dq_o_q;
    assign dq_o_en = dq_o_en_q;

`ifdef SDR_PROTOCOL_CHECK_EN
    localparam logic [2:0] CMD_RFR = 3'b001;
    localparam logic [3:0] TRCD_LD = (trcd > 0) ? 4'(trcd - 1) : 4'd0;
    localparam logic [3:0] TRP_LD  = (trp > 0) ? 4'(trp - 1) : 4'd0;

    logic [NB-1:0][3:0] rcd_q, rcd_d, rp_q, rp_d;
    logic [3:0]         err_q, err_d;

    // Per-bank counters hold the cycles still forbidden after ACT (tRCD) and PCH (tRP).
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            rcd_d[b] = (rcd_q[b] != 4'd0) ? rcd_q[b] - 4'd1 : 4'd0;
            rp_d[b]  = (rp_q[b] != 4'd0) ? rp_q[b] - 4'd1 : 4'd0;
        end
        err_d = err_q;
        if (is_act) begin
            if (open_q[ba])        err_d[0] = 1'b1;
            if (rp_q[ba] != 4'd0)  err_d[3] = 1'b1;
            rcd_d[ba] = TRCD_LD;
        end
        if (rw_cmd) begin
            if (!open_q[ba])            err_d[1] = 1'b1;
            else if (rcd_q[ba] != 4'd0) err_d[3] = 1'b1;
        end
        if (((cmd == CMD_RFR) || is_lmr) && (open_q != '0)) err_d[2] = 1'b1;
        if (is_pch) begin
            if (a[10]) begin
                for (int b = 0; b < NB; b++) rp_d[b] = TRP_LD;
            end else begin
                rp_d[ba] = TRP_LD;
            end
        end
        if (rw_ok && a[10]) rp_d[ba] = TRP_LD;
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            rcd_q <= '0;
            rp_q  <= '0;
            err_q <= '0;
        end else begin
            rcd_q <= rcd_d;
            rp_q  <= rp_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Timing parameters only matter to the checker.
    logic unused_timing;
    assign unused_timing = ^{4'(trcd), 4'(trp)};
    assign err = 4'b0000;
`endif

endmodule

// File: doc/sdr_16_responder.md
Name: sdr_16_responder

Overview:
Synthesizable single-data-rate 16-bit SDRAM responder: the device end of the controller's ba/a/cmd/dq interface.
- Decodes commands, tracks open rows per bank, holds the mode register, stores write bursts and returns read bursts after CAS latency.
- Backing store is an internal RAM; row/column bits beyond its depth alias.
- Used for FPGA loopback and controller regression without an external SDRAM part.

Parameters:
ba_size, 2, bank address bits (fixed 2 here)
row_size, 13, row address bits
col_size, 9, column address bits (must be <=10)
mem_adr_size, 12, log2 of backing RAM depth in 16-bit words; RAM address {ba, row[low], col[low]} truncated to this width
trcd, 2, min cycles ACT -> RD/WR, same bank (checker only)
trp, 2, min cycles PCH -> ACT, same bank (checker only)

Ports:
sdram_clk  input  1  clock, all logic on rising edge
sdram_rst  input  1  asynchronous active-high reset
ba  input  2  bank address
a  input  13  row / column / mode address
cmd  input  3  {ras_n,cas_n,we_n}: nop 111, act 011, rd 101, wr 100, pch 010, rfr 001, lmr 000
dq_i  input  16  write data from controller
dq_o  output  16  read data
dq_o_en  output  1  high while dq_o carries a valid read beat
err  output  4  sticky protocol error flags

Behaviour:
Sampling
- All inputs sampled at the rising edge. A command is "at edge n" when sampled there.

Reset
- Outputs and state after reset: dq_o=0, dq_o_en=0, err=0, all banks closed, no burst active.
- Mode register = {wb=0, cl=2, bt=0, bl=3'b001}.
- RAM contents are not cleared.
- Reset mid-burst aborts the burst; no later beats are driven.

LMR
- Captures wb=a[9], cl=a[6:4], bt=a[3], bl=a[2:0].
- Legal bl codes 000/001/010/011 = 1/2/4/8 beats; any other code acts as 1 beat.
- Legal cl 2 and 3; any other value acts as 2.

ACT
- Opens bank ba with row a[row_size-1:0]. ACT to an already-open bank replaces its row.

PCH
- a[10]=1: closes all banks. a[10]=0: closes bank ba.

RFR
- No data effect.

RD/WR
- col = a[col_size-1:0]. Bank must be open, otherwise the command is ignored.
- a[10]=1 (auto-precharge) closes the bank when the command is accepted; the burst still completes.

Burst addressing
- Beat k uses low log2(BL) column bits = start+k mod BL when bt=0, start^k when bt=1.
- Upper column bits are held from the command.

Write
- Beat 0 = dq_i at the WR edge n; beat k = dq_i at edge n+k.
- With wb=1 the write is a single beat.

Read
- Beat k is driven on dq_o with dq_o_en=1 so that it is sampled at edge n+CL+k; registers update at edge n+CL-1+k.
- Implemented as a 3-deep read pipeline plus a beat counter; cl is latched per command.

Burst termination
- A new RD or WR truncates the current burst: no further beats of the old burst are written or issued.
- Beats already in the CL pipeline still emerge.
- PCH to the bank of an active burst truncates it as well.

Simultaneous events
- Read beats from the pipeline and a write in the same cycle operate independently.
- A write and a read-fetch to the same RAM word in one cycle: the write lands first, so the read sees new data.

Optional Feature:
SDR_PROTOCOL_CHECK_EN
- Defined: err bits set sticky at the edge the violation is sampled; cleared only by reset.
  - err[0]: ACT to an open bank.
  - err[1]: RD/WR to a closed bank.
  - err[2]: RFR or LMR while any bank is open.
  - err[3]: tRCD (<trcd cycles ACT->RD/WR) or tRP (<trp cycles PCH->ACT) violation; per-bank down-counters.
- Not defined: err tied to 0, counters removed; command and data behaviour identical.

Test Plan:
1. Reset, then LMR a=0x021 (cl=2, bl=2), ACT ba=1 row=0x0ABC, wait 2, WR col=4 with dq_i 0x1111 then 0x2222, RD col=4 -> dq_o 0x1111 sampled at RD edge+2, 0x2222 at +3; dq_o_en high for exactly those 2 cycles; err=0.
2. LMR bl=8, bt=0, cl=3; write 0..7 at col 0; RD col=5 -> beats sampled from RD edge+3 carry data of cols 5,6,7,0,1,2,3,4. Repeat with bt=1 -> cols 5,4,7,6,1,0,3,2.
3. RD bl=8 interrupted by RD at a different column 3 cycles later -> exactly 3 old beats, then 8 new beats, with no gap.
4. RD to a closed bank -> dq_o_en stays 0; with SDR_PROTOCOL_CHECK_EN, err=4'b0010 from the next cycle onward.
5. ACT bank 0, RD one cycle later (trcd=2) -> err[3]=1. RFR with bank 2 open -> err[2]=1. PCH a[10]=1 then RFR -> no new error.
6. Assert sdram_rst during a read burst -> dq_o_en=0 immediately, err=0. Subsequent RD without ACT is ignored. Data written before reset is still readable after a new ACT.
